// File: rtl/alarm_pkg.sv
// Shared types and limits for the multi-slot alarm bank.
package alarm_pkg;

  localparam int         CNT_W  = 10;
  localparam logic [5:0] MAX_H  = 6'd23;
  localparam logic [5:0] MAX_MS = 6'd59;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    ARMED  = 3'd1,
    ALERT  = 3'd2,
    SNOOZE = 3'd3,
    DONE   = 3'd4
  } slot_state_t;

  typedef enum logic [1:0] {
    F_HOUR = 2'd0,
    F_MIN  = 2'd1,
    F_SEC  = 2'd2,
    F_EN   = 2'd3
  } field_t;

  // The enable field takes any data word; only bit 0 is stored.
  function automatic logic field_ok(input field_t f, input logic [5:0] d);
    case (f)
      F_HOUR:       return d <= MAX_H;
      F_MIN, F_SEC: return d <= MAX_MS;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// Setting-write and readback bus of the alarm bank.
interface alarm_bank_if #(
  parameter int SLOT_W = 2
);
  logic              WR_EN;
  logic [SLOT_W-1:0] WR_SLOT;
  logic [1:0]        WR_FIELD;
  logic [5:0]        WR_DATA;
  logic              WR_ERR;
  logic [SLOT_W-1:0] RD_SLOT;
  logic [5:0]        RD_H;
  logic [5:0]        RD_M;
  logic [5:0]        RD_S;
  logic              RD_EN;

  modport master (
    output WR_EN, WR_SLOT, WR_FIELD, WR_DATA, RD_SLOT,
    input  WR_ERR, RD_H, RD_M, RD_S, RD_EN
  );

  modport slave (
    input  WR_EN, WR_SLOT, WR_FIELD, WR_DATA, RD_SLOT,
    output WR_ERR, RD_H, RD_M, RD_S, RD_EN
  );
endinterface

// File: rtl/alarm_slot.sv
// One alarm slot: stored time and enable, alert FSM, timeout/snooze counter
// and snooze count.
module alarm_slot
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SEC  = 300,
  parameter int TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [5:0] time_h,
  input  logic [5:0] time_m,
  input  logic [5:0] time_s,
  input  logic       wr,
  input  field_t     wr_field,
  input  logic [5:0] wr_data,
  input  logic       ack,
  input  logic       snooze,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       en,
  output logic       alerting
);

  localparam logic [CNT_W-1:0] SNOOZE_LOAD  = CNT_W'(SNOOZE_SEC);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_SEC);
  localparam logic [7:0]       SNZ_MAX      = 8'(MAX_SNOOZE);

  slot_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_dec;
  logic [7:0]       snz_reg, snz_next;
  logic [5:0]       h_reg, m_reg, s_reg;
  logic             en_reg;
  logic             en_after;
  logic             match;

  assign match    = (h_reg == time_h) && (m_reg == time_m) && (s_reg == time_s);
  assign en_after = (wr_field == F_EN) ? wr_data[0] : en_reg;
  assign cnt_dec  = (cnt_reg == '0) ? '0 : cnt_reg - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= OFF;
      cnt_reg   <= '0;
      snz_reg   <= '0;
      h_reg     <= '0;
      m_reg     <= '0;
      s_reg     <= '0;
      en_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      snz_reg   <= snz_next;
      if (wr) begin
        case (wr_field)
          F_HOUR:  h_reg  <= wr_data;
          F_MIN:   m_reg  <= wr_data;
          F_SEC:   s_reg  <= wr_data;
          default: en_reg <= wr_data[0];
        endcase
      end
    end
  end

  // A write overrides every user or timer event for this slot in the same cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    snz_next   = snz_reg;
    if (wr) begin
      state_next = en_after ? ARMED : OFF;
      cnt_next   = '0;
      snz_next   = '0;
    end else begin
      case (state_reg)
        OFF: state_next = OFF;
        ARMED: begin
          if (sec_tick && match) begin
            state_next = ALERT;
            cnt_next   = TIMEOUT_LOAD;
            snz_next   = '0;
          end
        end
        ALERT: begin
          if (ack) begin
            state_next = DONE;
            cnt_next   = '0;
          end else if (snooze) begin
            if (snz_reg < SNZ_MAX) begin
              state_next = SNOOZE;
              cnt_next   = SNOOZE_LOAD;
              snz_next   = snz_reg + 8'd1;
            end else begin
              state_next = DONE;
              cnt_next   = '0;
            end
          end else if (sec_tick) begin
            cnt_next = cnt_dec;
            if (cnt_dec == '0) state_next = DONE;
          end
        end
        SNOOZE: begin
          if (ack) begin
            state_next = DONE;
            cnt_next   = '0;
          end else if (sec_tick) begin
            if (cnt_dec == '0) begin
              state_next = ALERT;
              cnt_next   = TIMEOUT_LOAD;
            end else begin
              cnt_next = cnt_dec;
            end
          end
        end
        DONE: begin
          // Hold off until the matching second has passed, so it cannot re-fire.
          if (sec_tick && !match) state_next = ARMED;
        end
        default: state_next = OFF;
      endcase
    end
  end

  assign hour     = h_reg;
  assign minute   = m_reg;
  assign second   = s_reg;
  assign en       = en_reg;
  assign alerting = (state_reg == ALERT);

endmodule

// File: rtl/alarm_bank.sv
// Bank of independent alarm slots with validated register-style writes,
// combinational readback and a registered lowest-index alert encoder.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS  = 4,
  parameter int SLOT_W      = 2,
  parameter int SNOOZE_SEC  = 300,
  parameter int TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  SEC_TICK,
  input  logic [5:0]            internalTime_H,
  input  logic [5:0]            internalTime_M,
  input  logic [5:0]            internalTime_S,
  input  logic                  ACK_SIG,
  input  logic                  SNOOZE_SIG,
  alarm_bank_if.slave           bus,
  output logic [NUM_ALARMS-1:0] ALARM_ALERT_VEC,
  output logic                  ALARM_ALERT_SIG,
  output logic [SLOT_W-1:0]     ALERT_SLOT
);

  field_t                wr_field;
  logic                  slot_ok, data_ok, wr_ok;
  logic                  wr_err_reg;
  logic [NUM_ALARMS-1:0] slot_wr;
  logic [NUM_ALARMS-1:0] alert_now;
  logic [NUM_ALARMS-1:0] slot_en;
  logic [5:0]            slot_h [NUM_ALARMS];
  logic [5:0]            slot_m [NUM_ALARMS];
  logic [5:0]            slot_s [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] vec_reg;
  logic                  sig_reg;
  logic [SLOT_W-1:0]     alert_slot_reg, alert_slot_next;

  assign wr_field = field_t'(bus.WR_FIELD);
  assign slot_ok  = int'(bus.WR_SLOT) < NUM_ALARMS;
  assign data_ok  = field_ok(wr_field, bus.WR_DATA);
  assign wr_ok    = bus.WR_EN && slot_ok && data_ok;

  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
    assign slot_wr[gi] = wr_ok && (bus.WR_SLOT == SLOT_W'(gi));

    alarm_slot #(
      .SNOOZE_SEC  (SNOOZE_SEC),
      .TIMEOUT_SEC (TIMEOUT_SEC),
      .MAX_SNOOZE  (MAX_SNOOZE)
    ) u_slot (
      .clk      (CLOCK_50),
      .rst      (RESET),
      .sec_tick (SEC_TICK),
      .time_h   (internalTime_H),
      .time_m   (internalTime_M),
      .time_s   (internalTime_S),
      .wr       (slot_wr[gi]),
      .wr_field (wr_field),
      .wr_data  (bus.WR_DATA),
      .ack      (ACK_SIG),
      .snooze   (SNOOZE_SIG),
      .hour     (slot_h[gi]),
      .minute   (slot_m[gi]),
      .second   (slot_s[gi]),
      .en       (slot_en[gi]),
      .alerting (alert_now[gi])
    );
  end

  // Out-of-range readback slots read as all zeros.
  always_comb begin
    bus.RD_H  = '0;
    bus.RD_M  = '0;
    bus.RD_S  = '0;
    bus.RD_EN = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (bus.RD_SLOT == SLOT_W'(i)) begin
        bus.RD_H  = slot_h[i];
        bus.RD_M  = slot_m[i];
        bus.RD_S  = slot_s[i];
        bus.RD_EN = slot_en[i];
      end
    end
  end

  always_comb begin
    alert_slot_next = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alert_now[i]) alert_slot_next = SLOT_W'(i);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      wr_err_reg     <= 1'b0;
      vec_reg        <= '0;
      sig_reg        <= 1'b0;
      alert_slot_reg <= '0;
    end else begin
      wr_err_reg     <= bus.WR_EN && !(slot_ok && data_ok);
      vec_reg        <= alert_now;
      sig_reg        <= |alert_now;
      alert_slot_reg <= alert_slot_next;
    end
  end

  assign bus.WR_ERR      = wr_err_reg;
  assign ALARM_ALERT_VEC = vec_reg;
  assign ALARM_ALERT_SIG = sig_reg;
  assign ALERT_SLOT      = alert_slot_reg;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed self-checking bench for alarm_bank: a write/readback vector table
// followed by hand-written alert, snooze, timeout, multi-slot and reset sequences.
module tb_alarm_bank;

  localparam int N_AL = 3;
  localparam int SW   = 2;

  logic            clk;
  logic            rst;
  logic            sec_tick;
  logic [5:0]      th, tm, ts;
  logic            ack;
  logic            snz;
  logic [N_AL-1:0] vec;
  logic            sig;
  logic [SW-1:0]   aslot;

  int compared;
  int mismatched;

  alarm_bank_if #(.SLOT_W(SW)) bus ();

  alarm_bank #(
    .NUM_ALARMS  (N_AL),
    .SLOT_W      (SW),
    .SNOOZE_SEC  (5),
    .TIMEOUT_SEC (60),
    .MAX_SNOOZE  (3)
  ) dut (
    .CLOCK_50        (clk),
    .RESET           (rst),
    .SEC_TICK        (sec_tick),
    .internalTime_H  (th),
    .internalTime_M  (tm),
    .internalTime_S  (ts),
    .ACK_SIG         (ack),
    .SNOOZE_SIG      (snz),
    .bus             (bus),
    .ALARM_ALERT_VEC (vec),
    .ALARM_ALERT_SIG (sig),
    .ALERT_SLOT      (aslot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] slot;
    logic [1:0] field;
    logic [5:0] data;
    logic [1:0] rd_slot;
    logic       err;
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       en;
  } wvec_t;

  wvec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] slot, input logic [1:0] field, input logic [5:0] data);
    bus.WR_EN    = 1'b1;
    bus.WR_SLOT  = slot;
    bus.WR_FIELD = field;
    bus.WR_DATA  = data;
    cycle();
    bus.WR_EN    = 1'b0;
  endtask

  task automatic tick(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    th       = h;
    tm       = m;
    ts       = s;
    sec_tick = 1'b1;
    cycle();
    sec_tick = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    cycle();
    ack = 1'b0;
  endtask

  task automatic pulse_snooze();
    snz = 1'b1;
    cycle();
    snz = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;

    // slot, field, data, rd_slot, err, h, m, s, en
    tbl[0]  = '{2'd0, 2'd0, 6'd24, 2'd0, 1'b1, 6'd0,  6'd0,  6'd0,  1'b0};
    tbl[1]  = '{2'd3, 2'd0, 6'd5,  2'd0, 1'b1, 6'd0,  6'd0,  6'd0,  1'b0};
    tbl[2]  = '{2'd0, 2'd1, 6'd60, 2'd0, 1'b1, 6'd0,  6'd0,  6'd0,  1'b0};
    tbl[3]  = '{2'd0, 2'd2, 6'd60, 2'd0, 1'b1, 6'd0,  6'd0,  6'd0,  1'b0};
    tbl[4]  = '{2'd0, 2'd0, 6'd23, 2'd0, 1'b0, 6'd23, 6'd0,  6'd0,  1'b0};
    tbl[5]  = '{2'd0, 2'd1, 6'd59, 2'd0, 1'b0, 6'd23, 6'd59, 6'd0,  1'b0};
    tbl[6]  = '{2'd0, 2'd2, 6'd59, 2'd0, 1'b0, 6'd23, 6'd59, 6'd59, 1'b0};
    tbl[7]  = '{2'd2, 2'd3, 6'd3,  2'd2, 1'b0, 6'd0,  6'd0,  6'd0,  1'b1};
    tbl[8]  = '{2'd2, 2'd3, 6'd2,  2'd2, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0};
    tbl[9]  = '{2'd1, 2'd0, 6'd7,  2'd1, 1'b0, 6'd7,  6'd0,  6'd0,  1'b0};
    tbl[10] = '{2'd1, 2'd1, 6'd30, 2'd1, 1'b0, 6'd7,  6'd30, 6'd0,  1'b0};
    tbl[11] = '{2'd1, 2'd2, 6'd0,  2'd1, 1'b0, 6'd7,  6'd30, 6'd0,  1'b0};
    tbl[12] = '{2'd1, 2'd3, 6'd1,  2'd1, 1'b0, 6'd7,  6'd30, 6'd0,  1'b1};

    rst          = 1'b1;
    sec_tick     = 1'b0;
    th           = '0;
    tm           = '0;
    ts           = '0;
    ack          = 1'b0;
    snz          = 1'b0;
    bus.WR_EN    = 1'b0;
    bus.WR_SLOT  = '0;
    bus.WR_FIELD = '0;
    bus.WR_DATA  = '0;
    bus.RD_SLOT  = '0;
    repeat (3) cycle();
    check("reset_vec", 32'(vec), 32'h0);
    check("reset_sig", 32'(sig), 32'h0);
    check("reset_slot", 32'(aslot), 32'h0);
    check("reset_wr_err", 32'(bus.WR_ERR), 32'h0);
    rst = 1'b0;
    cycle();

    for (int i = 0; i < 13; i++) begin
      bus.RD_SLOT = tbl[i].rd_slot;
      write(tbl[i].slot, tbl[i].field, tbl[i].data);
      check($sformatf("v%0d_wr_err", i), 32'(bus.WR_ERR), 32'(tbl[i].err));
      check($sformatf("v%0d_rd_h", i), 32'(bus.RD_H), 32'(tbl[i].h));
      check($sformatf("v%0d_rd_m", i), 32'(bus.RD_M), 32'(tbl[i].m));
      check($sformatf("v%0d_rd_s", i), 32'(bus.RD_S), 32'(tbl[i].s));
      check($sformatf("v%0d_rd_en", i), 32'(bus.RD_EN), 32'(tbl[i].en));
      cycle();
      check($sformatf("v%0d_wr_err_clear", i), 32'(bus.WR_ERR), 32'h0);
    end

    // Slot 1 alarm at 07:30:00: outputs follow the tick by one cycle.
    tick(6'd7, 6'd29, 6'd59);
    cycle();
    check("pre_match_vec", 32'(vec), 32'h0);
    tick(6'd7, 6'd30, 6'd0);
    check("match_latency_vec", 32'(vec), 32'h0);
    cycle();
    check("match_vec", 32'(vec), 32'h2);
    check("match_sig", 32'(sig), 32'h1);
    check("match_slot", 32'(aslot), 32'h1);

    // Three snoozes each re-alert after 5 ticks.
    for (int k = 0; k < 3; k++) begin
      pulse_snooze();
      cycle();
      check($sformatf("snooze%0d_drop", k), 32'(vec), 32'h0);
      for (int j = 1; j <= 4; j++) tick(6'd7, 6'd31, 6'(k * 10 + j));
      cycle();
      check($sformatf("snooze%0d_hold", k), 32'(vec), 32'h0);
      tick(6'd7, 6'd31, 6'(k * 10 + 5));
      cycle();
      check($sformatf("snooze%0d_return", k), 32'(vec), 32'h2);
    end
    // Fourth snooze is a dismissal.
    pulse_snooze();
    cycle();
    check("snooze_max_drop", 32'(vec), 32'h0);
    for (int j = 0; j < 5; j++) tick(6'd7, 6'd32, 6'(j));
    cycle();
    check("snooze_max_no_return", 32'(vec), 32'h0);

    // Auto-timeout with the time held at the alarm second.
    tick(6'd7, 6'd30, 6'd0);
    cycle();
    check("timeout_alert", 32'(vec), 32'h2);
    for (int j = 0; j < 59; j++) tick(6'd7, 6'd30, 6'd0);
    cycle();
    check("timeout_hold59", 32'(vec), 32'h2);
    tick(6'd7, 6'd30, 6'd0);
    cycle();
    check("timeout_clear", 32'(vec), 32'h0);
    tick(6'd7, 6'd30, 6'd0);
    cycle();
    check("timeout_no_retrigger", 32'(vec), 32'h0);
    tick(6'd7, 6'd30, 6'd1);
    tick(6'd7, 6'd30, 6'd0);
    cycle();
    check("rearm_alert", 32'(vec), 32'h2);
    pulse_ack();
    cycle();
    check("ack_single", 32'(vec), 32'h0);
    tick(6'd7, 6'd30, 6'd1);

    // Slots 0 and 2 share 12:00:00.
    write(2'd1, 2'd3, 6'd0);
    write(2'd0, 2'd0, 6'd12);
    write(2'd0, 2'd1, 6'd0);
    write(2'd0, 2'd2, 6'd0);
    write(2'd0, 2'd3, 6'd1);
    write(2'd2, 2'd0, 6'd12);
    write(2'd2, 2'd3, 6'd1);
    tick(6'd12, 6'd0, 6'd0);
    cycle();
    check("dual_vec", 32'(vec), 32'h5);
    check("dual_slot", 32'(aslot), 32'h0);
    check("dual_sig", 32'(sig), 32'h1);
    pulse_ack();
    cycle();
    check("dual_ack_vec", 32'(vec), 32'h0);
    check("dual_ack_sig", 32'(sig), 32'h0);

    // With slot 0 disabled only slot 2 fires.
    tick(6'd12, 6'd0, 6'd1);
    write(2'd0, 2'd3, 6'd0);
    tick(6'd12, 6'd0, 6'd0);
    cycle();
    check("slot2_vec", 32'(vec), 32'h4);
    check("slot2_slot", 32'(aslot), 32'h2);
    pulse_ack();
    write(2'd0, 2'd3, 6'd1);
    tick(6'd12, 6'd0, 6'd1);
    tick(6'd12, 6'd0, 6'd0);
    cycle();
    check("pre_reset_vec", 32'(vec), 32'h5);

    // Asynchronous reset mid-cycle clears everything at once.
    #2;
    rst = 1'b1;
    #1;
    bus.RD_SLOT = 2'd0;
    #1;
    check("async_reset_vec", 32'(vec), 32'h0);
    check("async_reset_sig", 32'(sig), 32'h0);
    check("async_reset_rd_en", 32'(bus.RD_EN), 32'h0);
    check("async_reset_rd_h", 32'(bus.RD_H), 32'h0);
    #1;
    rst = 1'b0;
    cycle();
    tick(6'd12, 6'd0, 6'd1);
    tick(6'd12, 6'd0, 6'd0);
    cycle();
    check("post_reset_no_alert", 32'(vec), 32'h0);
    tick(6'd0, 6'd0, 6'd0);
    cycle();
    check("post_reset_zero_time", 32'(vec), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Multi-slot successor to the single alarm-clock mode block; holds NUM_ALARMS independent alarm times, each with its own enable and alert state machine.
- Adds snooze, an alert auto-timeout and a synchronous register-style setting interface in place of edge-triggered setting strobes.
- Sits beside the timekeeping core, consuming internal H/M/S plus a 1 Hz tick; drives the buzzer/LED alert logic and the display mux.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..16).
- SLOT_W, 2, slot index width; must equal clog2(NUM_ALARMS), minimum 1.
- SNOOZE_SEC, 300, snooze duration in seconds (1..1023).
- TIMEOUT_SEC, 60, seconds in ALERT before automatic dismissal (1..1023).
- MAX_SNOOZE, 3, snoozes allowed per alarm event; further SNOOZE_SIG is treated as ACK.

Ports:
- CLOCK_50  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- SEC_TICK  in  1  one-cycle pulse at each seconds increment of the time core.
- internalTime_H / _M / _S  in  6 each  current time; H 0..23, M/S 0..59.
- WR_EN  in  1  setting write strobe, one cycle.
- WR_SLOT  in  SLOT_W  target slot.
- WR_FIELD  in  2  field select: 0 = hour, 1 = minute, 2 = second, 3 = enable (WR_DATA[0]).
- WR_DATA  in  6  write value.
- WR_ERR  out  1  one-cycle pulse when a write is rejected.
- ACK_SIG  in  1  user dismiss, level sampled each cycle.
- SNOOZE_SIG  in  1  user snooze, level sampled each cycle.
- RD_SLOT  in  SLOT_W  readback slot select.
- RD_H / RD_M / RD_S  out  6 each  stored time of RD_SLOT, combinational.
- RD_EN  out  1  enable bit of RD_SLOT.
- ALARM_ALERT_VEC  out  NUM_ALARMS  per-slot alerting flag, registered.
- ALARM_ALERT_SIG  out  1  OR of ALARM_ALERT_VEC.
- ALERT_SLOT  out  SLOT_W  lowest-index alerting slot; 0 when none.

Behaviour:
- Reset: all stored times 0, all enables 0, all FSMs OFF, snooze and timeout counters 0, every output 0.
- Writes are applied at the clock edge where WR_EN = 1.
  - Rejected when H > 23, M > 59, S > 59, or WR_SLOT >= NUM_ALARMS. A rejected write leaves state unchanged and pulses WR_ERR on the next cycle.
  - Any accepted write to a slot forces that slot's FSM to OFF, or to ARMED if the resulting enable = 1. Its counters and snooze count clear.
- Match for a slot = stored H/M/S equals the internal time. It is evaluated only on cycles with SEC_TICK = 1, using the time value present on that cycle.
- Per-slot FSM:
  - OFF: enable = 0. Enable write of 1 -> ARMED.
  - ARMED: SEC_TICK with match -> ALERT; timeout counter loads TIMEOUT_SEC and snooze count clears.
  - ALERT: vector bit = 1. Counter decrements on SEC_TICK.
    - ACK_SIG -> DONE.
    - SNOOZE_SIG with snooze count < MAX_SNOOZE -> SNOOZE; counter loads SNOOZE_SEC and snooze count increments.
    - SNOOZE_SIG with snooze count = MAX_SNOOZE -> DONE.
    - Counter reaching 0 -> DONE.
  - SNOOZE: vector bit = 0. Counter decrements on SEC_TICK; at 0 -> ALERT with the timeout counter reloaded. ACK_SIG -> DONE.
  - DONE: wait until a SEC_TICK with no match -> ARMED. This prevents re-trigger within the same second.
- Writing enable = 0 moves a slot to OFF from any state, with no further alert.
- ACK_SIG and SNOOZE_SIG apply to every slot in a qualifying state simultaneously.
- Priority when events coincide in one cycle:
  - write beats ACK;
  - ACK beats SNOOZE;
  - SNOOZE beats timeout;
  - a SNOOZE-expiry re-alert happens even while ACK is low.
- Counters are 10 bits unsigned and never wrap below 0.
- ALARM_ALERT_VEC, ALARM_ALERT_SIG and ALERT_SLOT update one cycle after the FSM transition.
- Several slots sharing the same time all alert; ALERT_SLOT reports the lowest index.
- Time jumps (clock set) skipping the alarm second produce no alert.

Decomposition:
- Package alarm_pkg holds:
  - slot state encoding (OFF, ARMED, ALERT, SNOOZE, DONE);
  - field codes (F_HOUR, F_MIN, F_SEC, F_EN);
  - limits (MAX_H = 23, MAX_MS = 59);
  - counter width 10.
- Sub-module alarm_slot is natural: one stored time and enable, one FSM, its counters and snooze count. alarm_bank instantiates it NUM_ALARMS times and adds write decode/validation, the readback mux and the priority encoder.

Test Plan:
- Reset, then write slot 1 = 07:30:00 with enable 1; drive time 07:29:59 -> 07:30:00 with SEC_TICK -> ALARM_ALERT_VEC = 0010 one cycle after the tick, ALERT_SLOT = 1.
- Write slot 0 hour = 24 -> WR_ERR pulse, RD_H for slot 0 still 0. Write to WR_SLOT = 3 with NUM_ALARMS = 3 -> WR_ERR pulse.
- Alert active, SNOOZE_SIG with SNOOZE_SEC = 5 -> alert drops; after 5 SEC_TICKs alert returns. Fourth snooze with MAX_SNOOZE = 3 -> DONE and no alert.
- Alert with no user input and TIMEOUT_SEC = 60 -> alert clears after 60 ticks; no re-alert while time stays equal; re-arms at the next non-matching tick.
- Slots 0 and 2 both set to 12:00:00 -> vector = 0101, ALERT_SLOT = 0. Single ACK_SIG -> both cleared.
- Alert active and RESET asserted mid-cycle -> all outputs 0 immediately, enables 0; no alert on the next match.
